// File: rtl/unpacker_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : unpacker_read_scheduler_if
// Brief    : Requester FIFO, converter and unpacked-output signals of the
//            shared unpacker read scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface unpacker_read_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int BURST_W   = 8
);
    logic [BURST_W-1:0]          burst_len;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          req_pop;
    logic                        cv_read_req;
    logic                        cv_read_ready;
    logic [IN_WIDTH-1:0]         cv_read_data;
    logic                        cv_write_req;
    logic [OUT_WIDTH-1:0]        cv_write_data;
    logic [NUM_REQ-1:0]          out_valid;
    logic [OUT_WIDTH-1:0]        out_data;
    logic [NUM_REQ-1:0]          grant;
    logic                        busy;

    // Environment side: requester FIFOs, converter and consumers.
    modport master (
        output burst_len, req_valid, req_data, cv_read_req, cv_write_req, cv_write_data,
        input  req_pop, cv_read_ready, cv_read_data, out_valid, out_data, grant, busy
    );

    // Scheduler side.
    modport slave (
        input  burst_len, req_valid, req_data, cv_read_req, cv_write_req, cv_write_data,
        output req_pop, cv_read_ready, cv_read_data, out_valid, out_data, grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/unpacker_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : unpacker_read_scheduler
// Brief    : Round-robin burst scheduler sharing one packed-to-unpacked
//            converter among NUM_REQ FIFOs. Optional counters under
//            macro UNPACK_SCHED_STATS_EN (stat_bursts, stat_words).
// Revision : 1.0 - initial release
// ============================================================================
module unpacker_read_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int BURST_W   = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    unpacker_read_scheduler_if.slave bus
`ifdef UNPACK_SCHED_STATS_EN
    ,
    output logic [31:0] stat_bursts,
    output logic [31:0] stat_words
`endif
);
    localparam int c_RATIO  = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int c_IDX_W  = $clog2(NUM_REQ);
    localparam int c_EMIT_W = BURST_W + $clog2(c_RATIO) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant,   w_grant_nxt;
    logic [c_IDX_W-1:0]   r_gidx,    w_gidx_nxt;
    logic [c_IDX_W-1:0]   r_ptr,     w_ptr_nxt;
    logic [BURST_W-1:0]   r_blen,    w_blen_nxt;
    logic [BURST_W-1:0]   r_issued,  w_issued_nxt;
    logic [c_EMIT_W-1:0]  r_emitted, w_emitted_nxt;

    logic                 w_pick_found;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_cur_valid;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_read_ready;
    logic [BURST_W:0]     w_issued_ext;
    logic [c_EMIT_W-1:0]  w_target;

    // Round-robin search: walk offsets high to low so the lowest offset from the pointer wins.
    always_comb begin
        int j;
        j            = 0;
        w_pick_idx   = r_ptr;
        w_pick_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req_valid[c_IDX_W'(j)]) begin
                w_pick_idx   = c_IDX_W'(j);
                w_pick_found = 1'b1;
            end
        end
    end

    assign w_cur_valid  = bus.req_valid[r_gidx];
    assign w_pop        = (r_state == ST_STREAM) && bus.cv_read_req;
    assign w_wr         = bus.cv_write_req && (r_state != ST_IDLE);
    assign w_issued_ext = {1'b0, r_issued} + {{BURST_W{1'b0}}, w_pop};
    assign w_target     = c_EMIT_W'(r_issued) * c_EMIT_W'(c_RATIO);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_ptr_nxt     = r_ptr;
        w_blen_nxt    = r_blen;
        w_issued_nxt  = r_issued;
        w_emitted_nxt = r_emitted;
        w_read_ready  = 1'b0;

        if (w_wr) w_emitted_nxt = r_emitted + c_EMIT_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt   = ST_STREAM;
                    w_grant_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                    w_gidx_nxt    = w_pick_idx;
                    w_blen_nxt    = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
                    w_issued_nxt  = '0;
                    w_emitted_nxt = '0;
                end
            end
            ST_STREAM: begin
                w_read_ready = w_cur_valid && (r_issued < r_blen);
                if (w_pop) w_issued_nxt = w_issued_ext[BURST_W-1:0];
                // A pop coinciding with the exit is still counted and drained.
                if ((w_issued_ext == {1'b0, r_blen}) || (!w_cur_valid && !w_pop))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_emitted == w_target) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (r_gidx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + c_IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_blen    <= '0;
            r_issued  <= '0;
            r_emitted <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_blen    <= w_blen_nxt;
            r_issued  <= w_issued_nxt;
            r_emitted <= w_emitted_nxt;
        end
    end

    assign bus.cv_read_ready = w_read_ready;
    assign bus.cv_read_data  = bus.req_data[r_gidx*IN_WIDTH +: IN_WIDTH];
    assign bus.req_pop       = r_grant & {NUM_REQ{w_pop}};
    assign bus.out_valid     = r_grant & {NUM_REQ{w_wr}};
    assign bus.out_data      = bus.cv_write_data;
    assign bus.grant         = r_grant;
    assign bus.busy          = (r_state != ST_IDLE);

`ifdef UNPACK_SCHED_STATS_EN
    logic [31:0] r_stat_bursts;
    logic [31:0] r_stat_words;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_bursts <= '0;
            r_stat_words  <= '0;
        end else begin
            if ((r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE) && (r_issued != '0))
                r_stat_bursts <= r_stat_bursts + 32'd1;
            if (|bus.out_valid)
                r_stat_words <= r_stat_words + 32'd1;
        end
    end

    assign stat_bursts = r_stat_bursts;
    assign stat_words  = r_stat_words;
`endif
endmodule
`default_nettype wire

// File: tb/tb_unpacker_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_unpacker_read_scheduler
// Brief    : Self-checking bench: FIFO/converter models, directed table,
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unpacker_read_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int IN_WIDTH  = 128;
    localparam int OUT_WIDTH = 64;
    localparam int BURST_W   = 8;
    localparam int RATIO     = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;

    typedef logic [IN_WIDTH-1:0]  word_t;
    typedef logic [OUT_WIDTH-1:0] slice_t;

    typedef struct {
        int req;
        int blen;
        int nwords;
        int exp_grants;
        int exp_outs;
        int exp_max_pops;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    unpacker_read_scheduler_if #(
        .NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .BURST_W(BURST_W)
    ) bus ();

`ifdef UNPACK_SCHED_STATS_EN
    logic [31:0] stat_bursts;
    logic [31:0] stat_words;
`endif

    unpacker_read_scheduler #(
        .NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .BURST_W(BURST_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef UNPACK_SCHED_STATS_EN
        ,
        .stat_bursts (stat_bursts),
        .stat_words  (stat_words)
`endif
    );

    // Environment and reference model state
    word_t  fifo_q [NUM_REQ][$];
    word_t  head_reg [NUM_REQ];
    slice_t exp_q [NUM_REQ][$];
    slice_t conv_q [$];
    int     glog [$];
    bit     pend_rd;
    word_t  pend_word;
    int     rd_pct, wr_pct;
    bit     inj_wr;
    bit     owner_act, pick_pending;
    int     owner, exp_pick, model_ptr, model_blen, burst_pops, max_pops;
    int     grants_cnt [NUM_REQ];
    int     outs_cnt [NUM_REQ];
    int     bursts_done, words_out;
    int     checks, errors;
    vec_t   tbl [5];

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic slice_t slice_of(input word_t w, input int k);
        word_t t;
        t = w >> (k * OUT_WIDTH);
        return t[OUT_WIDTH-1:0];
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int k = 0; k < IN_WIDTH / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string name, input logic [IN_WIDTH-1:0] act, input logic [IN_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_q[i].delete();
            exp_q[i].delete();
            head_reg[i]   = '0;
            grants_cnt[i] = 0;
            outs_cnt[i]   = 0;
        end
        conv_q.delete();
        glog.delete();
        pend_rd = 0; inj_wr = 0; owner_act = 0; pick_pending = 0;
        model_ptr = 0; burst_pops = 0; max_pops = 0; bursts_done = 0; words_out = 0;
        bus.req_valid = '0; bus.req_data = '0; bus.cv_read_req = 1'b0;
        bus.cv_write_req = 1'b0; bus.cv_write_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        bit do_rd, do_wr;
        logic [NUM_REQ-1:0] rv;
        word_t w;
        do_rd = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rv[i] = (fifo_q[i].size() > 0);
            bus.req_data[i*IN_WIDTH +: IN_WIDTH] = head_reg[i];
        end
        bus.req_valid = rv;
        do_wr = inj_wr || (conv_q.size() > 0 && $urandom_range(99) < wr_pct);
        bus.cv_write_req  = do_wr;
        bus.cv_write_data = inj_wr ? slice_t'({$urandom, $urandom}) : (conv_q.size() > 0 ? conv_q[0] : '0);
        bus.cv_read_req   = 1'b0;
        #1;
        if (pend_rd) begin
            chk("read_data", bus.cv_read_data, pend_word);
            for (int k = 0; k < RATIO; k++) conv_q.push_back(slice_of(bus.cv_read_data, k));
        end
        if (pick_pending) begin
            chk("grant", bus.grant, onehot(exp_pick));
            chk("busy_on_grant", bus.busy, 1);
            owner_act = 1; owner = exp_pick; burst_pops = 0; pick_pending = 0;
            grants_cnt[owner]++;
            glog.push_back(owner);
        end else if (owner_act && !bus.busy) begin
            chk("burst_len_limit", burst_pops <= model_blen, 1);
            chk("drained_before_idle", exp_q[owner].size(), 0);
            if (burst_pops > max_pops) max_pops = burst_pops;
            if (burst_pops > 0) bursts_done++;
            model_ptr = (owner + 1) % NUM_REQ;
            owner_act = 0;
        end
        if (!owner_act && !pick_pending) begin
            chk("idle_grant", bus.grant, 0);
            if (rv != '0) begin
                exp_pick     = rr_pick(model_ptr, rv);
                model_blen   = (bus.burst_len == '0) ? 1 : int'(bus.burst_len);
                pick_pending = 1;
            end
        end
        if (bus.cv_read_ready)
            chk("ready_allowed", owner_act && fifo_q[owner].size() > 0 && burst_pops < model_blen, 1);
        if (bus.cv_read_ready && !inj_wr && conv_q.size() <= 2 * RATIO && $urandom_range(99) < rd_pct)
            do_rd = 1;
        bus.cv_read_req = do_rd;
        #1;
        chk("req_pop", bus.req_pop, (do_rd && owner_act) ? onehot(owner) : '0);
        chk("out_valid", bus.out_valid, (do_wr && owner_act) ? onehot(owner) : '0);
        if (do_wr && owner_act) begin
            if (exp_q[owner].size() == 0) chk("unexpected_output", 1, 0);
            else chk("out_data", bus.out_data, exp_q[owner].pop_front());
            outs_cnt[owner]++;
            words_out++;
        end
        @(posedge clk);
        pend_rd = 0;
        if (do_rd && owner_act && fifo_q[owner].size() > 0) begin
            w = fifo_q[owner].pop_front();
            head_reg[owner] = w;
            for (int k = 0; k < RATIO; k++) exp_q[owner].push_back(slice_of(w, k));
            burst_pops++;
            pend_rd   = 1;
            pend_word = w;
        end
        if (do_wr && !inj_wr && conv_q.size() > 0) void'(conv_q.pop_front());
        @(negedge clk);
    endtask

    task automatic run_idle();
        int n;
        bit done;
        n = 0; done = 0;
        while (!done && n < 4000) begin
            tick();
            n++;
            done = !owner_act && !pick_pending && !pend_rd && conv_q.size() == 0 && !bus.busy;
            for (int i = 0; i < NUM_REQ; i++) if (fifo_q[i].size() > 0) done = 0;
        end
        chk("run_to_idle_timeout", done, 1);
    endtask

    task automatic load(input int r, input int n);
        for (int k = 0; k < n; k++) fifo_q[r].push_back(rand_word());
    endtask

    initial begin
        // {req, burst_len, words, grants, outputs, max pops per grant}
        tbl[0] = '{0, 3,   3, 1, 6,  3};
        tbl[1] = '{3, 0,   5, 5, 10, 1};
        tbl[2] = '{2, 2,   5, 3, 10, 2};
        tbl[3] = '{1, 200, 4, 1, 8,  4};
        tbl[4] = '{0, 1,   2, 2, 4,  1};
        checks = 0; errors = 0;
        rd_pct = 100; wr_pct = 100;
        reset = 1'b1;
        clear_model();
        bus.burst_len = 8'd1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '1; bus.cv_read_req = 1'b1; bus.cv_write_req = 1'b1;
        #1;
        chk("reset_grant", bus.grant, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_req_pop", bus.req_pop, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_read_ready", bus.cv_read_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_model();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NUM_REQ; i++) begin grants_cnt[i] = 0; outs_cnt[i] = 0; end
            max_pops = 0;
            bus.burst_len = BURST_W'(tbl[v].blen);
            load(tbl[v].req, tbl[v].nwords);
            run_idle();
            chk($sformatf("tbl%0d_grants", v), grants_cnt[tbl[v].req], tbl[v].exp_grants);
            chk($sformatf("tbl%0d_outputs", v), outs_cnt[tbl[v].req], tbl[v].exp_outs);
            chk($sformatf("tbl%0d_max_pops", v), max_pops, tbl[v].exp_max_pops);
        end

        // Converter output while idle must not reach any requester
        inj_wr = 1;
        tick();
        inj_wr = 0;

        // Two contending requesters alternate
        do_reset();
        bus.burst_len = 8'd2;
        load(0, 4);
        load(2, 4);
        run_idle();
        chk("alt_grant_count", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("alt_g0", glog[0], 0);
            chk("alt_g1", glog[1], 2);
            chk("alt_g2", glog[2], 0);
            chk("alt_g3", glog[3], 2);
        end
        chk("alt_outs0", outs_cnt[0], 8);
        chk("alt_outs2", outs_cnt[2], 8);

        // Early exit when the FIFO empties; pointer moves past the owner
        do_reset();
        bus.burst_len = 8'd4;
        load(1, 1);
        run_idle();
        chk("early_outs1", outs_cnt[1], 2);
        chk("early_grants1", grants_cnt[1], 1);
        glog.delete();
        load(0, 1);
        load(2, 1);
        run_idle();
        chk("ptr_after_req1", glog.size() > 0 ? glog[0] : -1, 2);

        // Reset mid-stream abandons the burst and clears the pointer
        do_reset();
        bus.burst_len = 8'd1;
        load(2, 1);
        run_idle();
        bus.burst_len = 8'd3;
        load(3, 3);
        for (int n = 0; n < 20 && !(owner_act && burst_pops >= 1); n++) tick();
        chk("midreset_setup", owner_act && burst_pops >= 1, 1);
        reset = 1'b1;
        bus.cv_read_req = 1'b0; bus.cv_write_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cv_read_req = 1'b1; bus.cv_write_req = 1'b1;
        #1;
        chk("midreset_grant", bus.grant, 0);
        chk("midreset_req_pop", bus.req_pop, 0);
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_busy", bus.busy, 0);
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        load(2, 1);
        load(3, 1);
        run_idle();
        chk("post_reset_pick", glog.size() > 0 ? glog[0] : -1, 2);

`ifdef UNPACK_SCHED_STATS_EN
        do_reset();
        bus.burst_len = 8'd3;
        load(0, 3);
        run_idle();
        bus.burst_len = 8'd4;
        load(1, 1);
        run_idle();
        chk("stat_bursts", stat_bursts, 2);
        chk("stat_words", stat_words, 8);
`endif

        // Randomized traffic with stalling converter
        do_reset();
        rd_pct = 60; wr_pct = 70;
        bus.burst_len = 8'd2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 25) begin
                int r;
                r = $urandom_range(NUM_REQ - 1);
                if (fifo_q[r].size() < 6) load(r, 1);
            end
            if ($urandom_range(99) < 5) bus.burst_len = BURST_W'($urandom_range(5));
            if (c == 1500) begin rd_pct = 90; wr_pct = 40; end
            tick();
        end
        run_idle();
        for (int i = 0; i < NUM_REQ; i++)
            chk($sformatf("rand_leftover%0d", i), exp_q[i].size(), 0);
`ifdef UNPACK_SCHED_STATS_EN
        chk("rand_stat_bursts", stat_bursts, bursts_done);
        chk("rand_stat_words", stat_words, words_out);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
